trail_write_sched: RTL and testbench
====================================

# trail_write_sched

Schedules trail-pixel writes into the shared frame-buffer SRAM port. On each frame tick during play, it latches both cycle positions and issues a burst of eight single-word writes: a 2x2 trail block for blue, then one for red. All writes go through a req/gnt handshake with the memory controller, which gives the VGA reader priority. The block sits between the game logic (positions, Game_State) and the SRAM arbiter.

## Interface
Parameters:
- ROW_STRIDE, 320, words per frame-buffer row
- X_OFFSET, 8, horizontal play-area offset in position units
- PLAYING, 3'b010, Game_State encoding for active play

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- frame_clk  in  1  ~60 Hz frame clock; asynchronous to Clk
- Game_State  in  3  current game state
- Blue_X, Blue_Y, Red_X, Red_Y  in  8 each  cycle positions
- Blue_color, Red_color  in  16 each  trail pixel words
- mem_gnt  in  1  controller accepts the current write this cycle
- mem_req  out  1  write request
- we  out  1  write enable; equals mem_req
- trail_addr  out  20  word address
- write  out  16  write data
- busy  out  1  high from LOAD through DONE
- frame_done  out  1  one-cycle pulse when a burst completes
- overrun  out  1  one-cycle pulse when a tick arrives while busy

## Operation
- frame_clk goes through a 2-FF synchronizer and a rising-edge detector, producing `tick`.
- FSM states:
  - IDLE: waits for tick && Game_State==PLAYING, then goes to LOAD. Ticks that arrive while not playing are ignored and do not pulse overrun.
  - LOAD: latches the four coordinates and both colors, clears beat counter k (3 bits), then goes to WRITE.
  - WRITE: mem_req=1. When mem_gnt=1, the beat transfers. If k==7 go to DONE; otherwise k++ and stay in WRITE. While mem_gnt=0, trail_addr, write and we hold stable.
  - DONE: frame_done=1 for one cycle, then go to IDLE.
- Beat mapping:
  - k[2]=0 selects blue; k[2]=1 selects red.
  - k[1] selects the row, k[0] selects the column.
- Address: base = (X+X_OFFSET)*2 + Y*4*ROW_STRIDE; trail_addr = base + k[1]*ROW_STRIDE + k[0].
  - Evaluate with latched coordinates, zero-extended to 20 bits. No overflow is possible for 8-bit inputs.
- write = latched color of the selected cycle.
- A tick that arrives in LOAD, WRITE or DONE pulses overrun for one cycle and is dropped. The burst in progress continues on its latched values.
- If Game_State leaves PLAYING in LOAD or WRITE, the FSM aborts to IDLE on the next edge. mem_req drops that edge and frame_done is not pulsed. A beat granted in the same cycle counts as complete.
- If the input positions change mid-burst, there is no effect.

## Timing
- Reset values: mem_req=0, we=0, trail_addr=0, write=0, busy=0, frame_done=0, overrun=0; state=IDLE; synchronizer flops=0.
- The state register updates on the Clk edge; outputs are decoded from registered state and counter (Moore).
- Tick latency: frame_clk is first sampled high at edge 1. tick is high after edge 2, state=LOAD after edge 3, and mem_req is first high after edge 4.
- With mem_gnt held at 1: 8 consecutive write cycles, then one DONE cycle. A burst takes 10 cycles from LOAD to return to IDLE.
- A transfer occurs only in a cycle where mem_req && mem_gnt are both high at the rising edge. mem_gnt while mem_req=0 is ignored.
- A Reset assertion mid-burst forces all outputs to their reset values immediately, asynchronously.

## Structure
- Package trail_pkg holds:
  - the FSM enum {IDLE, LOAD, WRITE, DONE}
  - constants PLAYING, ROW_STRIDE, X_OFFSET, shared with the trail and VGA logic
- Sub-module frame_tick_sync: 2-FF synchronizer plus rising-edge detector, with the same asynchronous active-low reset. Everything else lives in one module.

## Test plan
- Blue (0,0), Red (10,2), mem_gnt=1, one tick while PLAYING:
  - trail_addr = 16, 17, 336, 337, 2596, 2597, 2916, 2917 on consecutive cycles
  - write switches from Blue_color to Red_color at beat 4
  - frame_done pulses once
- Same stimulus with mem_gnt toggling 1,0,0,1…:
  - trail_addr, write and we hold through each stall
  - exactly 8 transfers occur, in the same order
- Second tick during a burst: overrun pulses for one cycle, the burst completes unchanged, and no second burst starts.
- Game_State changed to 3'b011 at beat 3: mem_req drops on the next edge, FSM returns to IDLE, no frame_done; the next tick in PLAYING starts a fresh burst at beat 0.
- Reset driven low at beat 5: all outputs go to 0 asynchronously. After release, the next tick starts a burst at beat 0 with newly latched positions.
- Tick with Game_State=3'b000: no mem_req, no overrun, busy stays 0.

Source files
------------

// File: rtl/trail_pkg.sv
// rtl/trail_pkg.sv - shared types and constants for trail writing and VGA logic
package trail_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] PLAYING    = 3'b010;
  localparam int unsigned ROW_STRIDE = 320;
  localparam int unsigned X_OFFSET   = 8;

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - brings frame_clk into the Clk domain as a one-cycle tick
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  // two-stage synchronizer followed by a one-cycle-delayed copy for edge detection
  always_comb begin
    s1_d   = async_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // synchronizer and edge-detect flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign tick = s2_q & ~prev_q;

endmodule

// File: rtl/trail_write_sched.sv
// rtl/trail_write_sched.sv - per-frame burst of eight trail-pixel writes into the frame buffer
module trail_write_sched #(
  parameter int unsigned ROW_STRIDE = trail_pkg::ROW_STRIDE,
  parameter int unsigned X_OFFSET   = trail_pkg::X_OFFSET,
  parameter logic [2:0]  PLAYING    = trail_pkg::PLAYING
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [2:0]  Game_State,
  input  logic [7:0]  Blue_X,
  input  logic [7:0]  Blue_Y,
  input  logic [7:0]  Red_X,
  input  logic [7:0]  Red_Y,
  input  logic [15:0] Blue_color,
  input  logic [15:0] Red_color,
  input  logic        mem_gnt,
  output logic        mem_req,
  output logic        we,
  output logic [19:0] trail_addr,
  output logic [15:0] write,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  import trail_pkg::*;

  logic   tick;
  logic   playing;
  state_t state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [7:0]  blue_x_q, blue_x_d, blue_y_q, blue_y_d;
  logic [7:0]  red_x_q, red_x_d, red_y_q, red_y_d;
  logic [15:0] blue_c_q, blue_c_d, red_c_q, red_c_d;

  logic [7:0]  sel_x, sel_y;
  logic [15:0] sel_color;
  logic [19:0] x_term, y_term, row_term, beat_addr;

  frame_tick_sync u_tick_sync (
    .clk      (Clk),
    .rst_n    (Reset),
    .async_in (frame_clk),
    .tick     (tick)
  );

  assign playing = (Game_State == PLAYING);

  // FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leaving play aborts an unfinished burst without completing it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (tick && playing) state_d = LOAD;
      LOAD:  state_d = playing ? WRITE : IDLE;
      WRITE: begin
        if (!playing)                   state_d = IDLE;
        else if (mem_gnt && k_q == 3'd7) state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // snapshot positions/colors in LOAD and step the beat counter on each granted write
  always_comb begin
    k_d      = k_q;
    blue_x_d = blue_x_q;
    blue_y_d = blue_y_q;
    red_x_d  = red_x_q;
    red_y_d  = red_y_q;
    blue_c_d = blue_c_q;
    red_c_d  = red_c_q;
    if (state_q == LOAD) begin
      k_d      = 3'd0;
      blue_x_d = Blue_X;
      blue_y_d = Blue_Y;
      red_x_d  = Red_X;
      red_y_d  = Red_Y;
      blue_c_d = Blue_color;
      red_c_d  = Red_color;
    end else if (state_q == WRITE && mem_gnt && k_q != 3'd7) begin
      k_d = k_q + 3'd1;
    end
  end

  // datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      k_q      <= '0;
      blue_x_q <= '0;
      blue_y_q <= '0;
      red_x_q  <= '0;
      red_y_q  <= '0;
      blue_c_q <= '0;
      red_c_q  <= '0;
    end else begin
      k_q      <= k_d;
      blue_x_q <= blue_x_d;
      blue_y_q <= blue_y_d;
      red_x_q  <= red_x_d;
      red_y_q  <= red_y_d;
      blue_c_q <= blue_c_d;
      red_c_q  <= red_c_d;
    end
  end

  // beat address: k[2] picks the cycle, k[1] the row and k[0] the column of its 2x2 block
  always_comb begin
    sel_x     = k_q[2] ? red_x_q : blue_x_q;
    sel_y     = k_q[2] ? red_y_q : blue_y_q;
    sel_color = k_q[2] ? red_c_q : blue_c_q;
    x_term    = (20'(sel_x) + 20'(X_OFFSET)) << 1;
    y_term    = 20'(sel_y) * 20'(4 * ROW_STRIDE);
    row_term  = k_q[1] ? 20'(ROW_STRIDE) : 20'd0;
    beat_addr = x_term + y_term + row_term + 20'(k_q[0]);
  end

  // FSM outputs, decoded from registered state; address and data are zero outside WRITE
  always_comb begin
    mem_req    = (state_q == WRITE);
    we         = mem_req;
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    overrun    = tick && busy;
    trail_addr = mem_req ? beat_addr : 20'd0;
    write      = mem_req ? sel_color : 16'd0;
  end

endmodule

// File: tb/tb_trail_write_sched.sv
// tb/tb_trail_write_sched.sv - randomized self-checking bench for trail_write_sched
module tb_trail_write_sched;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic [2:0]  Game_State = 3'b010;
  logic [7:0]  Blue_X = '0, Blue_Y = '0, Red_X = '0, Red_Y = '0;
  logic [15:0] Blue_color = '0, Red_color = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_req, we, busy, frame_done, overrun;
  logic [19:0] trail_addr;
  logic [15:0] write;

  int checks = 0;
  int errors = 0;

  trail_write_sched dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .Game_State (Game_State),
    .Blue_X     (Blue_X),
    .Blue_Y     (Blue_Y),
    .Red_X      (Red_X),
    .Red_Y      (Red_Y),
    .Blue_color (Blue_color),
    .Red_color  (Red_color),
    .mem_gnt    (mem_gnt),
    .mem_req    (mem_req),
    .we         (we),
    .trail_addr (trail_addr),
    .write      (write),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_addr"}, trail_addr, 0);
    chk({tag, "_write"}, write, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  // Reference: the 2x2 block sits at ((x+8)*2, 4*y) in a 320-word-wide buffer
  function automatic int ref_addr(input int x, input int y, input int beat);
    int row, col;
    row = (beat / 2) % 2;
    col = beat % 2;
    return (x + 8) * 2 + (y * 4 + row) * 320 + col;
  endfunction

  // gmode: 0 = grant always, 1 = grant pattern 1,0,0,1, 2 = random grant
  // ov_beat / ab_beat / rs_beat: beat at which to inject a tick, leave play, or reset (-1 = never)
  task automatic do_burst(input logic [7:0] bx, input logic [7:0] by,
                          input logic [7:0] rx, input logic [7:0] ry,
                          input int gmode, input int ov_beat,
                          input int ab_beat, input int rs_beat);
    int exp_a[8];
    logic [15:0] exp_w[8];
    logic [15:0] bc, rc;
    int cyc, beat, xfers, dones, ovs, first_req, busy_cycles, wcyc;
    int ov_cyc, ab_cyc;
    bit aborted, ov_done, reset_hit, g;

    bc = 16'($urandom);
    rc = 16'($urandom);
    Blue_X = bx; Blue_Y = by; Red_X = rx; Red_Y = ry;
    Blue_color = bc; Red_color = rc;
    Game_State = 3'b010;
    mem_gnt = 1'b0;
    for (int b = 0; b < 8; b++) begin
      exp_a[b] = (b < 4) ? ref_addr(int'(bx), int'(by), b) : ref_addr(int'(rx), int'(ry), b);
      exp_w[b] = (b < 4) ? bc : rc;
    end

    @(negedge Clk);
    frame_clk = 1'b1;
    cyc = 0; beat = 0; xfers = 0; dones = 0; ovs = 0; first_req = -1;
    busy_cycles = 0; wcyc = 0; ov_cyc = -1; ab_cyc = -1;
    aborted = 0; ov_done = 0; reset_hit = 0;

    while (cyc < 80 && !reset_hit) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 3) frame_clk = 1'b0;
      if (ov_cyc >= 0 && cyc == ov_cyc + 3) frame_clk = 1'b0;
      if (cyc == 6) begin
        Blue_X = 8'($urandom); Blue_Y = 8'($urandom);
        Red_X = 8'($urandom); Red_Y = 8'($urandom);
        Blue_color = 16'($urandom); Red_color = 16'($urandom);
      end
      if (busy) busy_cycles++;
      if (frame_done) dones++;
      if (overrun) ovs++;
      if (aborted && cyc == ab_cyc + 1) begin
        chk("abort_mem_req", mem_req, 0);
        chk("abort_busy", busy, 0);
      end
      mem_gnt = 1'b0;
      if (mem_req) begin
        if (first_req < 0) first_req = cyc;
        chk("beat_addr", trail_addr, exp_a[beat > 7 ? 7 : beat]);
        chk("beat_write", write, exp_w[beat > 7 ? 7 : beat]);
        chk("beat_we", we, 1);
        if (beat == rs_beat) begin
          Reset = 1'b0;
          #2;
          chk_all_zero("async_reset");
          reset_hit = 1;
        end else begin
          case (gmode)
            0:       g = 1;
            1:       g = (wcyc % 4 == 0) || (wcyc % 4 == 3);
            default: g = bit'($urandom_range(0, 1));
          endcase
          if (beat == ab_beat && !aborted) begin
            Game_State = 3'b011;
            g = 1;
            aborted = 1;
            ab_cyc = cyc;
          end
          if (beat == ov_beat && !ov_done) begin
            frame_clk = 1'b1;
            ov_done = 1;
            ov_cyc = cyc;
          end
          mem_gnt = g;
          wcyc++;
          if (g) begin
            xfers++;
            beat++;
          end
        end
      end
    end

    if (reset_hit) begin
      @(negedge Clk);
      frame_clk = 1'b0;
      mem_gnt = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
    end else begin
      chk("first_req_latency", first_req, 4);
      chk("transfers", xfers, (ab_beat >= 0) ? ab_beat + 1 : 8);
      chk("frame_done_pulses", dones, (ab_beat >= 0) ? 0 : 1);
      chk("overrun_pulses", ovs, (ov_beat >= 0) ? 1 : 0);
      if (gmode == 0 && ab_beat < 0) chk("busy_cycles", busy_cycles, 10);
      chk("end_busy", busy, 0);
    end
    frame_clk = 1'b0;
    mem_gnt = 1'b0;
    Game_State = 3'b010;
  endtask

  initial begin
    int bad_req, bad_ovr, bad_busy;

    // reset state
    #5;
    chk_all_zero("reset");
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // fixed positions: blue (0,0), red (10,2)
    do_burst(8'd0, 8'd0, 8'd10, 8'd2, 0, -1, -1, -1);
    do_burst(8'd0, 8'd0, 8'd10, 8'd2, 1, -1, -1, -1);

    // overrun tick mid-burst
    do_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 2, -1, -1);

    // leave play at beat 3, then a fresh burst
    do_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2, -1, 3, -1);
    repeat (3) @(negedge Clk);
    do_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, -1, -1, -1);

    // reset at beat 5, then a fresh burst with new positions
    do_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, -1, -1, 5);
    repeat (2) @(negedge Clk);
    do_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1, -1, -1, -1);

    // tick while not playing
    Game_State = 3'b000;
    bad_req = 0; bad_ovr = 0; bad_busy = 0;
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (i == 4) frame_clk = 1'b0;
      if (mem_req) bad_req++;
      if (overrun) bad_ovr++;
      if (busy) bad_busy++;
    end
    chk("notplay_mem_req_cycles", bad_req, 0);
    chk("notplay_overrun_cycles", bad_ovr, 0);
    chk("notplay_busy_cycles", bad_busy, 0);
    Game_State = 3'b010;
    repeat (4) @(negedge Clk);
    chk("notplay_stays_idle", busy, 0);

    // random positions, random grants
    for (int n = 0; n < 3; n++) begin
      do_burst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2, -1, -1, -1);
    end
    do_burst(8'd255, 8'd255, 8'd255, 8'd255, 0, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
